// File: rtl/mac_row_mm.sv
// Row of `col` signed saturating MAC PEs, weight-stationary or output-stationary.
// Activations and instructions ripple east one PE per cycle; results leave south.
module mac_row_mm #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic [bw-1:0]          in_w,
   input  logic [2:0]             inst_w,
   input  logic [psum_bw*col-1:0] in_n,
   output logic [psum_bw*col-1:0] out_s,
   output logic [col-1:0]         valid,
   output logic [col-1:0]         ovf
);
   localparam logic [psum_bw-1:0] PS_MAX = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic [psum_bw-1:0] PS_MIN = {1'b1, {(psum_bw-1){1'b0}}};

   // Returns {clamped, saturated two's-complement sum}.
   function automatic logic [psum_bw:0] sat_add(input logic [psum_bw-1:0] a,
                                                input logic [psum_bw-1:0] b);
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (s[psum_bw] != s[psum_bw-1])
         sat_add = {1'b1, (s[psum_bw] ? PS_MIN : PS_MAX)};
      else
         sat_add = {1'b0, s[psum_bw-1:0]};
   endfunction

   logic mode_d, mode_q, mode_chg;

   always_comb begin
      mode_d = mode;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mode_q <= 1'b0;
      else       mode_q <= mode_d;
   end

   assign mode_chg = mode ^ mode_q;

   logic [col-1:0][bw-1:0] act_in;
   logic [col-1:0][2:0]    inst_in;

   assign act_in[0]  = in_w;
   assign inst_in[0] = inst_w;

   for (genvar gi = 0; gi < col; gi++) begin : g_pe
      logic [bw-1:0]      weight_d, weight_q;
      logic               load_ready_d, load_ready_q;
      logic [psum_bw-1:0] acc_d, acc_q;
      logic [psum_bw-1:0] out_d, out_q;
      logic               valid_d, valid_q;
      logic               ovf_d, ovf_q;
      logic [bw-1:0]      w_eff;
      logic [psum_bw-1:0] psum_n, prod, acc_base;
      logic [psum_bw:0]   ws_sum, os_sum;
      logic               capture, ovf_base;

      assign psum_n = in_n[gi*psum_bw +: psum_bw];

      always_comb begin
         w_eff    = mode_q ? psum_n[bw-1:0] : (load_ready_q ? weight_q : '0);
         prod     = {{(psum_bw-bw){1'b0}}, act_in[gi]} *
                    {{(psum_bw-bw){w_eff[bw-1]}}, w_eff};
         // An unloaded PE consumes the load so the next value lands one PE further east.
         capture  = ~mode_q & inst_in[gi][0] & ~load_ready_q;
         acc_base = inst_in[gi][2] ? '0 : acc_q;
         ovf_base = inst_in[gi][2] ? 1'b0 : ovf_q;
         ws_sum   = sat_add(psum_n, prod);
         os_sum   = sat_add(acc_base, prod);

         weight_d     = weight_q;
         load_ready_d = load_ready_q;
         acc_d        = acc_q;
         out_d        = out_q;
         valid_d      = 1'b0;
         ovf_d        = ovf_q;

         if (mode_chg) begin
            load_ready_d = 1'b0;
            acc_d        = '0;
            ovf_d        = 1'b0;
         end else if (!mode_q) begin
            if (capture) begin
               weight_d     = act_in[gi];
               load_ready_d = 1'b1;
            end
            if (inst_in[gi][1]) begin
               out_d   = ws_sum[psum_bw-1:0];
               valid_d = 1'b1;
               ovf_d   = ovf_q | ws_sum[psum_bw];
            end
         end else begin
            if (inst_in[gi][2]) begin
               out_d   = acc_q;
               valid_d = 1'b1;
            end
            // Drain + execute restarts the accumulation from this cycle's product.
            if (inst_in[gi][1]) begin
               acc_d = os_sum[psum_bw-1:0];
               ovf_d = ovf_base | os_sum[psum_bw];
            end else begin
               acc_d = acc_base;
               ovf_d = ovf_base;
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            weight_q     <= '0;
            load_ready_q <= 1'b0;
            acc_q        <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
         end else begin
            weight_q     <= weight_d;
            load_ready_q <= load_ready_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
         end
      end

      if (gi < col-1) begin : g_fwd
         logic [bw-1:0] act_fwd_d, act_fwd_q;
         logic [2:0]    inst_fwd_d, inst_fwd_q;

         always_comb begin
            act_fwd_d  = act_in[gi];
            inst_fwd_d = mode_chg ? 3'b000
                                  : {inst_in[gi][2:1], inst_in[gi][0] & ~capture};
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               act_fwd_q  <= '0;
               inst_fwd_q <= '0;
            end else begin
               act_fwd_q  <= act_fwd_d;
               inst_fwd_q <= inst_fwd_d;
            end
         end

         assign act_in[gi+1]  = act_fwd_q;
         assign inst_in[gi+1] = inst_fwd_q;
      end

      assign out_s[gi*psum_bw +: psum_bw] = out_q;
      assign valid[gi]                    = valid_q;
      assign ovf[gi]                      = ovf_q;
   end
endmodule

// File: tb/tb_mac_row_mm.sv
// Scoreboard bench for mac_row_mm: a behavioural row model predicts every result
// when an instruction is issued; a negedge monitor matches results as they appear.
module tb_mac_row_mm;
   localparam int BW  = 4;
   localparam int PW  = 16;
   localparam int COL = 8;

   logic              clk    = 1'b0;
   logic              reset  = 1'b0;
   logic              mode   = 1'b0;
   logic [BW-1:0]     in_w   = '0;
   logic [2:0]        inst_w = '0;
   logic [PW*COL-1:0] in_n   = '0;
   logic [PW*COL-1:0] out_s;
   logic [COL-1:0]    valid;
   logic [COL-1:0]    ovf;

   mac_row_mm #(.bw(BW), .psum_bw(PW), .col(COL)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .inst_w(inst_w),
      .in_n(in_n), .out_s(out_s), .valid(valid), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
   endtask

   typedef struct {
      int cyc;
      int val;
      bit ovf;
   } exp_t;

   exp_t exp_q [COL][$];

   // Behavioural model state
   int wts    [COL];
   int nloaded;
   int acc_m  [COL];
   bit ovf_m  [COL];
   int last_m [COL];
   bit mode_m;
   int osw    [COL];

   function automatic int sat(input int v, output bit c);
      c = 1'b0;
      if (v > 32767)  begin c = 1'b1; return 32767;  end
      if (v < -32768) begin c = 1'b1; return -32768; end
      return v;
   endfunction

   function automatic int nin(input int j);
      logic signed [PW-1:0] s;
      s = in_n[j*PW +: PW];
      return s;
   endfunction

   function automatic int wos(input int j);
      logic signed [BW-1:0] s;
      s = in_n[j*PW +: BW];
      return s;
   endfunction

   function automatic int sext4(input int a);
      logic signed [BW-1:0] s;
      s = BW'(a);
      return s;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      nloaded = 0;
      for (int j = 0; j < COL; j++) begin
         acc_m[j] = 0;
         ovf_m[j] = 1'b0;
      end
   endtask

   // Drive one instruction for one cycle and predict what each column will produce.
   task automatic issue(input logic [2:0] ins, input int a);
      in_w   = BW'(a);
      inst_w = ins;
      for (int j = 0; j < COL; j++) begin
         int   p, base, old;
         bit   c, ob;
         exp_t e;
         c = 1'b0;
         if (!mode_m) begin
            if (ins[1]) begin
               p = a * ((j < nloaded) ? wts[j] : 0);
               e.val = sat(nin(j) + p, c);
               ovf_m[j] = ovf_m[j] | c;
               e.ovf = ovf_m[j];
               e.cyc = cyc + 1 + j;
               exp_q[j].push_back(e);
               last_m[j] = e.val;
            end
         end else begin
            p    = a * wos(j);
            old  = acc_m[j];
            base = ins[2] ? 0 : acc_m[j];
            ob   = ins[2] ? 1'b0 : ovf_m[j];
            if (ins[1]) begin
               acc_m[j] = sat(base + p, c);
               ovf_m[j] = ob | c;
            end else begin
               acc_m[j] = base;
               ovf_m[j] = ob;
            end
            if (ins[2]) begin
               e.val = old;
               e.ovf = ovf_m[j];
               e.cyc = cyc + 1 + j;
               exp_q[j].push_back(e);
               last_m[j] = old;
            end
         end
      end
      if (!mode_m && ins[0] && nloaded < COL) begin
         wts[nloaded] = sext4(a);
         nloaded++;
      end
      @(posedge clk);
      #1;
      in_w   = '0;
      inst_w = '0;
   endtask

   task automatic set_n_all(input int v);
      for (int j = 0; j < COL; j++) in_n[j*PW +: PW] = PW'(v);
   endtask

   task automatic set_n_rand();
      for (int j = 0; j < COL; j++) in_n[j*PW +: PW] = PW'($urandom);
   endtask

   // OS weights from osw[], upper slice bits randomised (they must be ignored).
   task automatic set_os();
      for (int j = 0; j < COL; j++) begin
         logic [PW-1:0] t;
         t = PW'($urandom);
         t[BW-1:0] = BW'(osw[j]);
         in_n[j*PW +: PW] = t;
      end
   endtask

   task automatic set_mode(input bit m);
      mode = m;
      step(2);
      mode_m = m;
      model_clear();
   endtask

   task automatic idle_check(input string tag);
      step(COL + 3);
      chk(valid == '0, {tag, " valid idle"}, int'(valid), 0);
      for (int j = 0; j < COL; j++) begin
         logic signed [PW-1:0] s;
         s = out_s[j*PW +: PW];
         chk(s == last_m[j], $sformatf("%s out_s hold col%0d", tag, j), int'(s), last_m[j]);
         chk(ovf[j] == ovf_m[j], $sformatf("%s ovf col%0d", tag, j), int'(ovf[j]), int'(ovf_m[j]));
      end
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk(out_s == '0, "async reset out_s", $countones(out_s), 0);
      chk(valid == '0, "async reset valid", int'(valid), 0);
      chk(ovf == '0, "async reset ovf", int'(ovf), 0);
      for (int j = 0; j < COL; j++) begin
         exp_q[j].delete();
         last_m[j] = 0;
      end
      model_clear();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int j = 0; j < COL; j++) begin
            exp_t e;
            logic signed [PW-1:0] s;
            if (valid[j]) begin
               chk(exp_q[j].size() != 0, $sformatf("spurious valid col%0d", j), 1, 0);
               if (exp_q[j].size() != 0) begin
                  e = exp_q[j].pop_front();
                  s = out_s[j*PW +: PW];
                  chk(e.cyc == cyc, $sformatf("valid timing col%0d", j), cyc, e.cyc);
                  chk(s == e.val, $sformatf("out_s col%0d", j), int'(s), e.val);
                  chk(ovf[j] == e.ovf, $sformatf("ovf at result col%0d", j),
                      int'(ovf[j]), int'(e.ovf));
                  $display("rx col=%0d cyc=%0d out_s=%0d ovf=%0b", j, cyc, s, ovf[j]);
               end
            end else if (exp_q[j].size() != 0 && exp_q[j][0].cyc <= cyc) begin
               chk(valid[j], $sformatf("missing valid col%0d", j), int'(valid[j]), 1);
               void'(exp_q[j].pop_front());
            end
         end
      end
   end

   initial begin
      int left;
      mode_m  = 1'b0;
      nloaded = 0;
      for (int j = 0; j < COL; j++) begin
         wts[j]    = 0;
         acc_m[j]  = 0;
         ovf_m[j]  = 1'b0;
         last_m[j] = 0;
      end

      #1 reset = 1'b1;
      #1;
      chk(out_s == '0, "reset out_s", $countones(out_s), 0);
      chk(valid == '0, "reset valid", int'(valid), 0);
      chk(ovf == '0, "reset ovf", int'(ovf), 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1);

      // WS: load 1..7,-1 then execute in_w=3 with psum 10
      for (int k = 0; k < COL; k++) issue(3'b001, (k == COL-1) ? 15 : k + 1);
      set_n_all(10);
      issue(3'b010, 3);
      idle_check("ws basic");

      // Second load burst passes through; weights stay
      for (int k = 0; k < COL; k++) issue(3'b001, int'($urandom_range(15, 0)));
      set_n_rand();
      for (int k = 0; k < 3; k++) issue(3'b010, int'($urandom_range(15, 0)));
      idle_check("ws reload");

      set_n_all(32760);
      issue(3'b010, 3);
      idle_check("ws sat hi");
      set_n_all(-32768);
      issue(3'b010, 3);
      idle_check("ws sat lo");

      for (int r = 0; r < 4; r++) begin
         set_n_rand();
         for (int k = 0; k < 1 + r; k++) issue(3'b010, int'($urandom_range(15, 0)));
         idle_check("ws random");
      end

      // Asynchronous reset mid-stream, then a fresh load
      set_n_all(10);
      issue(3'b010, 5);
      issue(3'b010, 6);
      step(2);
      mid_reset();
      idle_check("post reset");
      for (int k = 0; k < COL; k++) issue(3'b001, int'($urandom_range(15, 0)));
      set_n_rand();
      for (int k = 0; k < 4; k++) issue(3'b010, int'($urandom_range(15, 0)));
      idle_check("ws new weights");

      // OS accumulate / drain
      set_mode(1'b1);
      for (int j = 0; j < COL; j++) osw[j] = 7;
      set_os();
      for (int k = 0; k < 4; k++) issue(3'b010, 15);
      issue(3'b100, 0);
      idle_check("os drain 420");
      issue(3'b100, 0);
      idle_check("os drain empty");

      // Drain + execute collision
      for (int k = 0; k < 4; k++) issue(3'b010, 15);
      step(COL + 2);
      for (int j = 0; j < COL; j++) osw[j] = 3;
      set_os();
      issue(3'b110, 2);
      issue(3'b100, 0);
      idle_check("os collide");

      // OS saturation in both directions, cleared by drain
      osw = '{7, -8, 7, -8, 3, -3, 1, 0};
      set_os();
      for (int k = 0; k < 320; k++) issue(3'b010, 15);
      idle_check("os sat");
      issue(3'b100, 0);
      idle_check("os sat drained");

      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < COL; j++) osw[j] = int'($urandom_range(15, 0));
         set_os();
         for (int k = 0; k < 20; k++) begin
            logic [2:0] ins;
            ins = 3'($urandom_range(7, 0));
            issue(ins, int'($urandom_range(15, 0)));
         end
         issue(3'b100, 0);
         idle_check("os random");
      end

      // Mode switch while holding an accumulation
      for (int j = 0; j < COL; j++) osw[j] = 5;
      set_os();
      for (int k = 0; k < 3; k++) issue(3'b010, 9);
      step(COL + 2);
      set_mode(1'b0);
      set_mode(1'b1);
      issue(3'b100, 0);
      idle_check("os after switch");

      // Back to WS: nothing loaded, so execute passes in_n through
      set_mode(1'b0);
      set_n_rand();
      issue(3'b010, int'($urandom_range(15, 1)));
      idle_check("ws unloaded");
      for (int k = 0; k < COL; k++) issue(3'b001, int'($urandom_range(15, 0)));
      for (int k = 0; k < 3; k++) issue(3'b010, int'($urandom_range(15, 0)));
      idle_check("ws reloaded");

      step(COL + 3);
      left = 0;
      for (int j = 0; j < COL; j++) left += exp_q[j].size();
      chk(left == 0, "results never produced", left, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
